mem_wb_ctrl: RTL and testbench

- Consumer end of the ALU output bus in the 8-bit processor. Registers each ALU result, runs the data-memory access (load/store) over a req/ack handshake, performs register-file writeback, issues PC redirects for JMP and taken branches, and latches halt.
- Sits between the combinational ALU and the data memory / GPR file. Provides backpressure (o_ready) to the fetch/decode front end.

---
 rtl/mem_wb_pkg.sv | 19 +
 rtl/mem_wb_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_wb_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types and widths for the memory/writeback stage.
//   state_e     : controller states (IDLE, MEM, WB, HALT)
//   MW_DATA_W   : datapath / memory data width
//   MW_ADDR_W   : data-memory address and PC target width
//   MW_REG_AW   : GPR address width
package mem_wb_pkg;

   localparam int MW_DATA_W = 8;
   localparam int MW_ADDR_W = 8;
   localparam int MW_REG_AW = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_WB   = 2'd2,
      S_HALT = 2'd3
   } state_e;

endpackage

// File: rtl/mem_wb_ctrl.sv
// mem_wb_ctrl: consumer of the ALU output bus. Registers each accepted ALU
// result and performs exactly one of: halt, PC redirect, data-memory access
// (req/ack), GPR writeback, or nothing (NOP). Counts retired instructions.
// Ports:
//   i_clk, i_rst          clock (rising) / async active-high reset
//   i_valid, o_ready      instruction handshake from the front end
//   i_results..i_jmp      ALU result, store data, regdest and control bits
//   o_dmem_* / i_dmem_*   data-memory request, held until ack
//   o_rf_*                one-cycle GPR write strobe, address and data
//   o_pc_load/o_pc_target one-cycle PC redirect
//   o_flag_q, o_halted, o_retired  architectural flag, sticky halt, counter
module mem_wb_ctrl
   import mem_wb_pkg::*;
#(
   parameter int DATA_W = MW_DATA_W,
   parameter int ADDR_W = MW_ADDR_W,
   parameter int REG_AW = MW_REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_results,
   input  logic [DATA_W-1:0] i_st_data,
   input  logic [REG_AW-1:0] i_regdest,
   input  logic              i_flag,
   input  logic              i_mem_write,
   input  logic              i_mem_read,
   input  logic              i_reg_write,
   input  logic              i_hlt,
   input  logic              i_branch_taken,
   input  logic              i_jmp,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [ADDR_W-1:0] o_dmem_addr,
   output logic [DATA_W-1:0] o_dmem_wdata,
   input  logic              i_dmem_ack,
   input  logic [DATA_W-1:0] i_dmem_rdata,
   output logic              o_rf_we,
   output logic [REG_AW-1:0] o_rf_addr,
   output logic [DATA_W-1:0] o_rf_wdata,
   output logic              o_pc_load,
   output logic [ADDR_W-1:0] o_pc_target,
   output logic              o_flag_q,
   output logic              o_halted,
   output logic [CNT_W-1:0]  o_retired
);

   state_e              state_q, state_d;
   logic                dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
   logic [REG_AW-1:0]   ld_rd_q, ld_rd_d;
   logic                rf_we_q, rf_we_d;
   logic [REG_AW-1:0]   rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
   logic                pc_load_q, pc_load_d;
   logic [ADDR_W-1:0]   pc_target_q, pc_target_d;
   logic                flag_q, flag_d;
   logic [CNT_W-1:0]    retired_q, retired_d;
   logic                retire;

   always_comb begin
      state_d      = state_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      ld_rd_d      = ld_rd_q;
      rf_we_d      = 1'b0;
      rf_addr_d    = rf_addr_q;
      rf_wdata_d   = rf_wdata_q;
      pc_load_d    = 1'b0;
      pc_target_d  = pc_target_q;
      flag_d       = flag_q;
      retire       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               // Flag follows ALU ops that write a register; loads leave it alone.
               if (i_reg_write && !i_mem_read) flag_d = i_flag;
               if (i_hlt) begin
                  state_d = S_HALT;
                  retire  = 1'b1;
               end else if (i_jmp || i_branch_taken) begin
                  pc_load_d   = 1'b1;
                  pc_target_d = ADDR_W'(i_results);
                  retire      = 1'b1;
               end else if (i_mem_read || i_mem_write) begin
                  state_d      = S_MEM;
                  dmem_addr_d  = ADDR_W'(i_results);
                  dmem_wdata_d = i_st_data;
                  dmem_we_d    = i_mem_write;   // write wins over read
                  ld_rd_d      = i_regdest;
               end else if (i_reg_write) begin
                  rf_we_d    = 1'b1;
                  rf_addr_d  = i_regdest;
                  rf_wdata_d = i_results;
                  retire     = 1'b1;
               end else begin
                  retire = 1'b1;
               end
            end
         end
         S_MEM: begin
            if (i_dmem_ack) begin
               if (dmem_we_q) begin
                  state_d = S_IDLE;
                  retire  = 1'b1;
               end else begin
                  // Strobe is registered so it lands in the WB cycle itself.
                  state_d    = S_WB;
                  rf_we_d    = 1'b1;
                  rf_addr_d  = ld_rd_q;
                  rf_wdata_d = i_dmem_rdata;
               end
            end
         end
         S_WB: begin
            state_d = S_IDLE;
            retire  = 1'b1;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         ld_rd_q      <= '0;
         rf_we_q      <= 1'b0;
         rf_addr_q    <= '0;
         rf_wdata_q   <= '0;
         pc_load_q    <= 1'b0;
         pc_target_q  <= '0;
         flag_q       <= 1'b0;
         retired_q    <= '0;
      end else begin
         state_q      <= state_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         ld_rd_q      <= ld_rd_d;
         rf_we_q      <= rf_we_d;
         rf_addr_q    <= rf_addr_d;
         rf_wdata_q   <= rf_wdata_d;
         pc_load_q    <= pc_load_d;
         pc_target_q  <= pc_target_d;
         flag_q       <= flag_d;
         retired_q    <= retired_d;
      end
   end

   // Request is decoded from state so an async reset drops it at once.
   // Ready is masked by reset so every output reads 0 while reset is held.
   assign o_ready      = (state_q == S_IDLE) && !i_rst;
   assign o_dmem_req   = (state_q == S_MEM);
   assign o_halted     = (state_q == S_HALT);
   assign o_dmem_we    = dmem_we_q;
   assign o_dmem_addr  = dmem_addr_q;
   assign o_dmem_wdata = dmem_wdata_q;
   assign o_rf_we      = rf_we_q;
   assign o_rf_addr    = rf_addr_q;
   assign o_rf_wdata   = rf_wdata_q;
   assign o_pc_load    = pc_load_q;
   assign o_pc_target  = pc_target_q;
   assign o_flag_q     = flag_q;
   assign o_retired    = retired_q;

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// tb_mem_wb_ctrl: directed + randomized checks of mem_wb_ctrl against a
// transaction-level reference (expected effect of each instruction).
module tb_mem_wb_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_valid, o_ready;
   logic [7:0] i_results, i_st_data;
   logic [1:0] i_regdest;
   logic       i_flag, i_mem_write, i_mem_read, i_reg_write, i_hlt, i_branch_taken, i_jmp;
   logic       o_dmem_req, o_dmem_we, i_dmem_ack;
   logic [7:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
   logic       o_rf_we;
   logic [1:0] o_rf_addr;
   logic [7:0] o_rf_wdata;
   logic       o_pc_load;
   logic [7:0] o_pc_target;
   logic       o_flag_q, o_halted;
   logic [15:0] o_retired;

   always #5 clk = ~clk;

   mem_wb_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_results(i_results), .i_st_data(i_st_data), .i_regdest(i_regdest),
      .i_flag(i_flag), .i_mem_write(i_mem_write), .i_mem_read(i_mem_read),
      .i_reg_write(i_reg_write), .i_hlt(i_hlt), .i_branch_taken(i_branch_taken),
      .i_jmp(i_jmp), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
      .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
      .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
      .o_rf_we(o_rf_we), .o_rf_addr(o_rf_addr), .o_rf_wdata(o_rf_wdata),
      .o_pc_load(o_pc_load), .o_pc_target(o_pc_target), .o_flag_q(o_flag_q),
      .o_halted(o_halted), .o_retired(o_retired)
   );

   int errs = 0;
   int checks = 0;

   // reference state
   logic        m_flag;
   logic [15:0] m_ret;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_in();
      i_valid = 0; i_hlt = 0; i_jmp = 0; i_branch_taken = 0;
      i_mem_read = 0; i_mem_write = 0; i_reg_write = 0; i_flag = 0;
      i_results = 0; i_st_data = 0; i_regdest = 0;
   endtask

   // Random traffic on inputs that must be ignored while not ready.
   task automatic garbage();
      i_valid = 1'b1;
      {i_hlt, i_jmp, i_branch_taken, i_mem_read, i_mem_write, i_reg_write, i_flag} = 7'($urandom);
      i_results = 8'($urandom); i_st_data = 8'($urandom); i_regdest = 2'($urandom);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, o_ready, 0);
      chk({tag, "_req"}, o_dmem_req, 0);
      chk({tag, "_we"}, o_dmem_we, 0);
      chk({tag, "_addr"}, o_dmem_addr, 0);
      chk({tag, "_rfwe"}, o_rf_we, 0);
      chk({tag, "_pcld"}, o_pc_load, 0);
      chk({tag, "_flag"}, o_flag_q, 0);
      chk({tag, "_halt"}, o_halted, 0);
      chk({tag, "_ret"}, o_retired, 0);
   endtask

   // Issue one instruction at a negedge and check its effect.
   // wt = idle ack cycles before ack; rdata = load return data.
   task automatic instr(input logic hlt, jmp, br, mr, mw, rw, flg,
                        input logic [7:0] res, st, input logic [1:0] rd,
                        input int wt, input logic [7:0] rdata);
      chk("ready_pre", o_ready, 1);
      i_valid = 1; i_hlt = hlt; i_jmp = jmp; i_branch_taken = br;
      i_mem_read = mr; i_mem_write = mw; i_reg_write = rw; i_flag = flg;
      i_results = res; i_st_data = st; i_regdest = rd;
      i_dmem_ack = 1'($urandom);  // ack while no request must be ignored
      if (rw && !mr) m_flag = flg;
      cyc();
      i_valid = 0;
      if (hlt) begin
         m_ret++;
         chk("halted", o_halted, 1);
         chk("halt_ready", o_ready, 0);
      end else if (jmp || br) begin
         m_ret++;
         chk("pc_load", o_pc_load, 1);
         chk("pc_target", o_pc_target, res);
         chk("jmp_rfwe", o_rf_we, 0);
         chk("jmp_req", o_dmem_req, 0);
      end else if (mr || mw) begin
         int reqc = 1;
         chk("mem_req", o_dmem_req, 1);
         chk("mem_we", o_dmem_we, mw);
         chk("mem_addr", o_dmem_addr, res);
         if (mw) chk("mem_wdata", o_dmem_wdata, st);
         chk("mem_ready", o_ready, 0);
         for (int k = 0; k < wt; k++) begin
            garbage();
            i_dmem_ack = 0;
            cyc();
            if (o_dmem_req) reqc++;
            chk("wait_addr", o_dmem_addr, res);
            chk("wait_ready", o_ready, 0);
         end
         chk("req_cycles", reqc, wt + 1);
         i_dmem_ack = 1; i_dmem_rdata = rdata;
         cyc();
         i_dmem_ack = 0;
         chk("ack_req_drop", o_dmem_req, 0);
         if (mw) begin
            m_ret++;
            chk("st_ready", o_ready, 1);
            chk("st_rfwe", o_rf_we, 0);
         end else begin
            chk("ld_rfwe", o_rf_we, 1);
            chk("ld_rfaddr", o_rf_addr, rd);
            chk("ld_rfdata", o_rf_wdata, rdata);
            chk("wb_ready", o_ready, 0);
            garbage();
            cyc();
            m_ret++;
            chk("wb_rfwe_off", o_rf_we, 0);
            chk("wb_ready_back", o_ready, 1);
         end
         clr_in();
      end else if (rw) begin
         m_ret++;
         chk("alu_rfwe", o_rf_we, 1);
         chk("alu_rfaddr", o_rf_addr, rd);
         chk("alu_rfdata", o_rf_wdata, res);
         chk("alu_pcld", o_pc_load, 0);
      end else begin
         m_ret++;
         chk("nop_rfwe", o_rf_we, 0);
         chk("nop_pcld", o_pc_load, 0);
         chk("nop_req", o_dmem_req, 0);
      end
      chk("flag", o_flag_q, m_flag);
      chk("retired", o_retired, m_ret);
   endtask

   task automatic do_reset();
      rst = 1;
      clr_in();
      i_dmem_ack = 0; i_dmem_rdata = 0;
      #1;
      check_zero("rst");
      cyc(); cyc();
      rst = 0;
      m_flag = 0; m_ret = 0;
      cyc();
      chk("rst_ready", o_ready, 1);
   endtask

   initial begin
      rst = 1;
      clr_in();
      i_dmem_ack = 0; i_dmem_rdata = 0;
      @(negedge clk);
      do_reset();

      // directed: ADD, LDM, ST, JMP + back-to-back ALU writes
      instr(0,0,0,0,0,1,1, 8'h2C, 8'h00, 2'd2, 0, 8'h00);
      instr(0,0,0,1,0,1,0, 8'h13, 8'h00, 2'd1, 2, 8'hA5);
      instr(0,0,0,0,1,0,0, 8'h40, 8'h7E, 2'd0, 0, 8'h00);
      instr(0,1,0,0,0,0,0, 8'h10, 8'h00, 2'd0, 0, 8'h00);
      instr(0,0,0,0,0,1,0, 8'h31, 8'h00, 2'd3, 0, 8'h00);
      instr(0,0,0,0,0,1,1, 8'h32, 8'h00, 2'd0, 0, 8'h00);
      instr(0,0,0,0,0,1,0, 8'h33, 8'h00, 2'd1, 0, 8'h00);
      // both read and write: write wins; reg_write ignored on store
      instr(0,0,0,1,1,1,1, 8'h55, 8'h66, 2'd3, 1, 8'h99);

      // randomized mix
      for (int n = 0; n < 60; n++) begin
         int c = $urandom_range(0, 4);
         logic [7:0] r = 8'($urandom), s = 8'($urandom), d = 8'($urandom);
         logic [1:0] g = 2'($urandom);
         logic f = 1'($urandom), x = 1'($urandom), y = 1'($urandom), z = 1'($urandom);
         int w = $urandom_range(0, 3);
         case (c)
            0: instr(0, x, !x | y, y, z, f, 1'($urandom), r, s, g, w, d);
            1: instr(0, 0, 0, 1, 0, x, f, r, s, g, w, d);
            2: instr(0, 0, 0, y, 1, x, f, r, s, g, w, d);
            3: instr(0, 0, 0, 0, 0, 1, f, r, s, g, 0, d);
            default: instr(0, 0, 0, 0, 0, 0, f, r, s, g, 0, d);
         endcase
      end

      // reset in the middle of a memory wait, then a late ack
      i_valid = 1; i_mem_read = 1; i_results = 8'h21; i_regdest = 2'd2;
      cyc();
      clr_in();
      chk("rmid_req", o_dmem_req, 1);
      #2 rst = 1;
      #1;
      check_zero("rmid");
      cyc();
      rst = 0;
      i_dmem_ack = 1; i_dmem_rdata = 8'hEE;
      cyc();
      i_dmem_ack = 0;
      chk("late_ack_req", o_dmem_req, 0);
      chk("late_ack_rfwe", o_rf_we, 0);
      chk("late_ack_ready", o_ready, 1);
      chk("late_ack_ret", o_retired, 0);
      m_flag = 0; m_ret = 0;

      // counter wrap: 65535 back-to-back NOPs, then HLT retires to 0
      i_valid = 1;
      repeat (65535) @(posedge clk);
      @(negedge clk);
      i_valid = 0;
      m_ret = 16'hFFFF;
      chk("ret_ffff", o_retired, 16'hFFFF);
      instr(1, 1, 0, 1, 0, 1, 1, 8'h77, 8'h00, 2'd1, 0, 8'h00);
      chk("ret_wrap", o_retired, 16'h0000);

      // halt is absorbing
      for (int k = 0; k < 8; k++) begin
         garbage();
         i_dmem_ack = 1'($urandom);
         cyc();
         chk("halt_stay", o_halted, 1);
         chk("halt_noready", o_ready, 0);
      end
      chk("halt_ret", o_retired, m_ret);
      clr_in();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
